sr_ff_bank: RTL and testbench

Parametrised bank of WIDTH clocked set/reset flip-flops, the synchronous successor to the single cross-coupled NOR RS latch. Each channel has its own S/R pair. The S=R=1 case is resolved by a compile-time mode rather than left to race. The bank adds parallel load, per-bit change pulses and a saturating conflict counter. It sits between debounced button/switch inputs and the lab display/control logic as a status and flag register.

---
 rtl/sr_ff_bank.sv | 94 +++++++++
 tb/tb_sr_ff_bank.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked set/reset flip-flops with parallel load, per-bit change
// pulses and a saturating counter of cycles in which any channel saw S=R=1.
module sr_ff_bank #(
    parameter int unsigned       WIDTH         = 8,
    parameter int unsigned       CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0]  INIT          = '0,
    parameter int unsigned       CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] changed,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    if (CONFLICT_MODE > 3) begin : g_bad_mode
        $error("sr_ff_bank: CONFLICT_MODE must be 0..3");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sr_ff_bank: WIDTH must be 1..32");
    end
    if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
        $error("sr_ff_bank: CNT_W must be 2..16");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] resolved;
    logic [WIDTH-1:0] sr_next;
    logic             hit;

    always_comb begin
        both = s & r;
        // Value each channel takes when both requests are active.
        case (CONFLICT_MODE)
            1:       resolved = '1;
            2:       resolved = '0;
            3:       resolved = ~q_q;
            default: resolved = q_q;
        endcase
        sr_next = (s & ~r) | (q_q & ~s & ~r) | (both & resolved);
        hit     = en & ~load & (|both);

        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (en) begin
            q_d = sr_next;
        end

        changed_d  = q_d ^ q_q;
        conflict_d = hit;

        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q        <= INIT;
            changed_q  <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            changed_q  <= changed_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign q            = q_q;
    assign q_n          = ~q_q;
    assign changed      = changed_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: four instances (one per conflict mode) share stimulus and
// are compared against a per-bit behavioural model of the set/reset rules.
module tb_sr_ff_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] s, r, d;
    logic       load;
    logic       clr_cnt;

    logic [7:0] q_a       [4];
    logic [7:0] q_n_a     [4];
    logic [7:0] changed_a [4];
    logic       conflict_a[4];
    logic [1:0] cnt_a     [4];

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq   [4];
    logic [7:0] mchg [4];
    logic       mconf;
    int         mcnt;

    always #5 clk = ~clk;

    for (genvar gm = 0; gm < 4; gm++) begin : g_dut
        sr_ff_bank #(
            .WIDTH        (8),
            .CONFLICT_MODE(gm),
            .INIT         (8'hA5),
            .CNT_W        (2)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en),
            .s           (s),
            .r           (r),
            .load        (load),
            .d           (d),
            .clr_cnt     (clr_cnt),
            .q           (q_a[gm]),
            .q_n         (q_n_a[gm]),
            .changed     (changed_a[gm]),
            .conflict    (conflict_a[gm]),
            .conflict_cnt(cnt_a[gm])
        );
    end

    function automatic logic next_bit(int mode, logic qb, logic sb, logic rb);
        if (sb && !rb) return 1'b1;
        if (rb && !sb) return 1'b0;
        if (!sb && !rb) return qb;
        case (mode)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return !qb;
            default: return qb;
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            mq[m]   = 8'hA5;
            mchg[m] = 8'h00;
        end
        mconf = 1'b0;
        mcnt  = 0;
    endtask

    // Advance one clock edge, update the model from the inputs seen at that edge.
    task automatic tick();
        logic       hit;
        logic [7:0] nq;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            hit = en && !load && ((s & r) != 8'h00);
            for (int m = 0; m < 4; m++) begin
                if (load) nq = d;
                else if (!en) nq = mq[m];
                else for (int b = 0; b < 8; b++) nq[b] = next_bit(m, mq[m][b], s[b], r[b]);
                mchg[m] = nq ^ mq[m];
                mq[m]   = nq;
            end
            mconf = hit;
            if (clr_cnt) mcnt = 0;
            else if (hit && mcnt < 3) mcnt = mcnt + 1;
        end
        #1;
    endtask

    task automatic set_in(logic e, logic [7:0] sv, logic [7:0] rv, logic l, logic [7:0] dv, logic c);
        en = e; s = sv; r = rv; load = l; d = dv; clr_cnt = c;
    endtask

    task automatic test_reset();
        set_in(1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0);
        tick();
        set_in(1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_a[m] !== 8'hA5 || q_n_a[m] !== 8'h5A || changed_a[m] !== 8'h00 ||
                conflict_a[m] !== 1'b0 || cnt_a[m] !== 2'd0) begin
                failures++;
                $display("FAIL reset_async mode%0d: q=%h q_n=%h chg=%h conf=%b cnt=%0d, want q=a5 q_n=5a chg=00 conf=0 cnt=0",
                         m, q_a[m], q_n_a[m], changed_a[m], conflict_a[m], cnt_a[m]);
            end
        end
        #3 rst_n = 1'b1;
        set_in(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_a[m] !== 8'hA5 || changed_a[m] !== 8'h00) begin
                failures++;
                $display("FAIL reset_release mode%0d: q=%h chg=%h, want q=a5 chg=00", m, q_a[m], changed_a[m]);
            end
        end
    endtask

    task automatic test_basic_sr();
        set_in(1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
        tick();
        set_in(1'b1, 8'h0F, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_a[m] !== 8'h0F || changed_a[m] !== 8'h0F || conflict_a[m] !== 1'b0) begin
                failures++;
                $display("FAIL basic_set mode%0d: q=%h chg=%h conf=%b, want q=0f chg=0f conf=0",
                         m, q_a[m], changed_a[m], conflict_a[m]);
            end
        end
        set_in(1'b1, 8'h00, 8'h03, 1'b0, 8'h00, 1'b0);
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_a[m] !== 8'h0C || changed_a[m] !== 8'h03 || q_n_a[m] !== 8'hF3) begin
                failures++;
                $display("FAIL basic_reset mode%0d: q=%h chg=%h q_n=%h, want q=0c chg=03 q_n=f3",
                         m, q_a[m], changed_a[m], q_n_a[m]);
            end
        end
        set_in(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_a[m] !== 8'h0C || changed_a[m] !== 8'h00) begin
                failures++;
                $display("FAIL basic_hold mode%0d: q=%h chg=%h, want q=0c chg=00", m, q_a[m], changed_a[m]);
            end
        end
    endtask

    task automatic test_conflict_modes();
        logic [7:0] exp1 [4];
        logic [7:0] exp2 [4];
        exp1 = '{8'hF0, 8'hFF, 8'h00, 8'h0F};
        exp2 = '{8'hF0, 8'hFF, 8'h00, 8'hF0};
        set_in(1'b1, 8'h00, 8'h00, 1'b1, 8'hF0, 1'b0);
        tick();
        set_in(1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_a[m] !== exp1[m] || conflict_a[m] !== 1'b1 || changed_a[m] !== (exp1[m] ^ 8'hF0)) begin
                failures++;
                $display("FAIL conflict_edge1 mode%0d: q=%h conf=%b chg=%h, want q=%h conf=1 chg=%h",
                         m, q_a[m], conflict_a[m], changed_a[m], exp1[m], exp1[m] ^ 8'hF0);
            end
        end
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_a[m] !== exp2[m] || conflict_a[m] !== 1'b1 || changed_a[m] !== (exp2[m] ^ exp1[m])) begin
                failures++;
                $display("FAIL conflict_edge2 mode%0d: q=%h conf=%b chg=%h, want q=%h conf=1 chg=%h",
                         m, q_a[m], conflict_a[m], changed_a[m], exp2[m], exp2[m] ^ exp1[m]);
            end
        end
    endtask

    task automatic test_priority();
        int cnt_before;
        set_in(1'b1, 8'h00, 8'h00, 1'b1, 8'h55, 1'b0);
        tick();
        set_in(1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_a[m] !== 8'h55 || changed_a[m] !== 8'h00 || conflict_a[m] !== 1'b0) begin
                failures++;
                $display("FAIL prio_en_low mode%0d: q=%h chg=%h conf=%b, want q=55 chg=00 conf=0",
                         m, q_a[m], changed_a[m], conflict_a[m]);
            end
        end
        set_in(1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
        tick();
        cnt_before = mcnt;
        set_in(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h3C, 1'b0);
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_a[m] !== 8'h3C || conflict_a[m] !== 1'b0 || int'(cnt_a[m]) != cnt_before) begin
                failures++;
                $display("FAIL prio_load mode%0d: q=%h conf=%b cnt=%0d, want q=3c conf=0 cnt=%0d",
                         m, q_a[m], conflict_a[m], cnt_a[m], cnt_before);
            end
        end
    endtask

    task automatic test_counter();
        int exp_seq [5];
        exp_seq = '{1, 2, 3, 3, 3};
        set_in(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        set_in(1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int m = 0; m < 4; m++) begin
                checks++;
                if (int'(cnt_a[m]) != exp_seq[i] || conflict_a[m] !== 1'b1) begin
                    failures++;
                    $display("FAIL counter_sat cycle%0d mode%0d: cnt=%0d conf=%b, want cnt=%0d conf=1",
                             i, m, cnt_a[m], conflict_a[m], exp_seq[i]);
                end
            end
        end
        clr_cnt = 1'b1;
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (cnt_a[m] !== 2'd0) begin
                failures++;
                $display("FAIL counter_clr mode%0d: cnt=%0d, want 0", m, cnt_a[m]);
            end
        end
        clr_cnt = 1'b0;
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (cnt_a[m] !== 2'd1) begin
                failures++;
                $display("FAIL counter_after_clr mode%0d: cnt=%0d, want 1", m, cnt_a[m]);
            end
        end
    endtask

    task automatic test_async_toggle();
        set_in(1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
        repeat (3) begin
            tick();
            checks++;
            if (changed_a[3] !== 8'hFF || q_a[3] !== mq[3]) begin
                failures++;
                $display("FAIL toggle_run mode3: q=%h chg=%h, want q=%h chg=ff", q_a[3], changed_a[3], mq[3]);
            end
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_a[m] !== 8'hA5 || changed_a[m] !== 8'h00 || cnt_a[m] !== 2'd0) begin
                failures++;
                $display("FAIL toggle_reset mode%0d: q=%h chg=%h cnt=%0d, want q=a5 chg=00 cnt=0",
                         m, q_a[m], changed_a[m], cnt_a[m]);
            end
        end
        #3 rst_n = 1'b1;
        set_in(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_a[m] !== 8'hA5 || changed_a[m] !== 8'h00) begin
                failures++;
                $display("FAIL toggle_release mode%0d: q=%h chg=%h, want q=a5 chg=00", m, q_a[m], changed_a[m]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 7) != 0);
            load    = ($urandom_range(0, 9) == 0);
            clr_cnt = ($urandom_range(0, 11) == 0);
            s       = 8'($urandom);
            r       = 8'($urandom) & 8'($urandom);
            d       = 8'($urandom);
            tick();
            for (int m = 0; m < 4; m++) begin
                checks++;
                if (q_a[m] !== mq[m] || q_n_a[m] !== ~mq[m] || changed_a[m] !== mchg[m] ||
                    conflict_a[m] !== mconf || int'(cnt_a[m]) != mcnt) begin
                    failures++;
                    $display("FAIL random cycle%0d mode%0d: q=%h q_n=%h chg=%h conf=%b cnt=%0d, want q=%h q_n=%h chg=%h conf=%b cnt=%0d",
                             i, m, q_a[m], q_n_a[m], changed_a[m], conflict_a[m], cnt_a[m],
                             mq[m], ~mq[m], mchg[m], mconf, mcnt);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        test_reset();
        test_basic_sr();
        test_conflict_modes();
        test_priority();
        test_counter();
        test_async_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
